// File: rtl/hilo_pkg.sv
// Shared definitions for the HI/LO register file and its iterative divider:
// operation codes, divide step count and FSM state encodings.
package hilo_pkg;

  localparam logic [2:0] OP_NONE  = 3'd0;
  localparam logic [2:0] OP_WRMUL = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  localparam int DIV_STEPS = 32;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DIV  = 2'd1,
    S_FIX  = 2'd2
  } state_t;

endpackage

// File: rtl/hilo_unit_div_step.sv
// One combinational restoring-division step: shift the next dividend bit into
// the partial remainder and keep the trial difference when it is non-negative.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0] rem_in,
  input  logic [WIDTH:0] divisor,
  input  logic           dividend_bit,
  output logic [WIDTH:0] rem_out,
  output logic           q_bit
);

  localparam int RW = WIDTH + 1;

  logic [WIDTH+1:0] shifted;

  always_comb begin
    shifted = {rem_in, dividend_bit};
    q_bit   = (shifted >= {1'b0, divisor});
    rem_out = q_bit ? RW'(shifted - {1'b0, divisor}) : RW'(shifted);
  end

endmodule

// File: rtl/hilo_unit.sv
// HI/LO registers for the mMIPS datapath: captures MULTU products, services
// MTHI/MTLO and runs DIV/DIVU as a fixed 33-cycle restoring sequence.
module hilo_unit
  import hilo_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] alu_lo,
  input  logic [WIDTH-1:0] alu_hi,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done
);

  localparam int CNT_W = $clog2(DIV_STEPS);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;

  logic [WIDTH:0]     rem_q, rem_d;
  logic [WIDTH:0]     div_q, div_d;
  logic [WIDTH-1:0]   quo_q, quo_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic               neg_quo_q, neg_quo_d;
  logic               neg_rem_q, neg_rem_d;
  logic               div_zero_q, div_zero_d;

  logic               is_signed;
  logic [WIDTH:0]     a_ext, b_ext, mag_a, mag_b;
  logic [WIDTH-1:0]   rem_word, rem_fix, quo_fix;
  logic [WIDTH:0]     step_rem;
  logic               step_q;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_in       (rem_q),
    .divisor      (div_q),
    .dividend_bit (quo_q[WIDTH-1]),
    .rem_out      (step_rem),
    .q_bit        (step_q)
  );

  // Magnitudes are taken on WIDTH+1 bits so the most negative value is exact.
  always_comb begin
    is_signed = (op == OP_DIV);
    a_ext     = {is_signed & a[WIDTH-1], a};
    b_ext     = {is_signed & b[WIDTH-1], b};
    mag_a     = a_ext[WIDTH] ? -a_ext : a_ext;
    mag_b     = b_ext[WIDTH] ? -b_ext : b_ext;
    rem_word  = WIDTH'(rem_q);
    rem_fix   = neg_rem_q ? -rem_word : rem_word;
    quo_fix   = neg_quo_q ? -quo_q : quo_q;
  end

  always_comb begin
    // NOTE: every _d defaults to its _q first so no path through the case
    // statement leaves a signal unassigned and infers a latch.
    state_d    = state_q;
    count_d    = count_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    hi_d       = hi_q;
    lo_d       = lo_q;
    rem_d      = rem_q;
    div_d      = div_q;
    quo_d      = quo_q;
    a_d        = a_q;
    neg_quo_d  = neg_quo_q;
    neg_rem_d  = neg_rem_q;
    div_zero_d = div_zero_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          case (op)
            OP_WRMUL: begin
              hi_d = alu_hi;
              lo_d = alu_lo;
            end
            OP_MTHI: hi_d = a;
            OP_MTLO: lo_d = a;
            OP_DIV, OP_DIVU: begin
              state_d    = S_DIV;
              count_d    = CNT_W'(DIV_STEPS - 1);
              busy_d     = 1'b1;
              rem_d      = '0;
              div_d      = mag_b;
              quo_d      = WIDTH'(mag_a);
              a_d        = a;
              neg_quo_d  = is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
              neg_rem_d  = is_signed & a[WIDTH-1];
              div_zero_d = (b == '0);
            end
            default: ;
          endcase
        end
      end
      S_DIV: begin
        // Dividend bits leave the top of quo_q as quotient bits enter the bottom.
        rem_d = step_rem;
        quo_d = {quo_q[WIDTH-2:0], step_q};
        if (count_q == '0) begin
          state_d = S_FIX;
        end else begin
          count_d = count_q - CNT_W'(1);
        end
      end
      S_FIX: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
        if (div_zero_q) begin
          hi_d = a_q;
          lo_d = '1;
        end else begin
          hi_d = rem_fix;
          lo_d = quo_fix;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the values from before the edge, independent of statement order.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= S_IDLE;
      count_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  // NOTE: operand latches carry no reset; they are always loaded on the
  // accepting edge before the FSM reads them.
  always_ff @(posedge clock) begin
    rem_q      <= rem_d;
    div_q      <= div_d;
    quo_q      <= quo_d;
    a_q        <= a_d;
    neg_quo_q  <= neg_quo_d;
    neg_rem_q  <= neg_rem_d;
    div_zero_q <= div_zero_d;
  end

  assign hi   = hi_q;
  assign lo   = lo_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule
